// File: rtl/psum_acc_pkg.sv
// Shared definitions for the partial-sum accumulator: beat field layout,
// FSM states and output saturation limits.
package psum_acc_pkg;

    localparam int ID_W = 8;
    localparam int P1_W = 24;
    localparam int P3_W = 32;

    localparam int ID_MSB = 63;
    localparam int ID_LSB = 56;
    localparam int P1_MSB = 55;
    localparam int P1_LSB = 32;
    localparam int P3_MSB = 31;
    localparam int P3_LSB = 0;

    localparam int SAT_MAX = 127;
    localparam int SAT_MIN = 0;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_t;

endpackage

// File: rtl/psum_acc_ram.sv
// Simple dual-port psum store: one write port, one registered read port.
// Read data holds whenever no read is issued.
module psum_acc_ram #(
    parameter int DEPTH = 1024,
    parameter int AW    = 10,
    parameter int DW    = 32
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/psum_acc.sv
// Per-output-channel accumulator: sums RepVGG branches, accumulates across
// input-channel passes and emits requantised int8 bytes on the last pass.
module psum_acc
    import psum_acc_pkg::*;
#(
    parameter int PSUM_DEPTH = 1024,
    parameter int AW         = 10,
    parameter int ACC_W      = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        acc_start,
    output logic        acc_done,
    input  logic [7:0]  in_ch,
    input  logic [15:0] map_size,
    input  logic [4:0]  quant_shift,
    input  logic [31:0] in_addr,
    input  logic [63:0] in_data,
    input  logic        in_vld,
    output logic        in_rdy,
    output logic [31:0] out_addr,
    output logic [7:0]  out_data,
    output logic        out_vld,
    input  logic        out_rdy
);

    state_t      state;
    logic [7:0]  in_ch_r;
    logic [15:0] map_size_r;
    logic [4:0]  shift_r;
    logic [15:0] pix_cnt;
    logic [7:0]  ch_cnt;

    logic stall;
    logic advance;
    logic accept;

    logic signed [ID_W-1:0] id_f;
    logic signed [P1_W-1:0] p1_f;
    logic signed [P3_W-1:0] p3_f;
    logic [ACC_W-1:0]       beat_sum;

    logic             s1_vld, s1_first, s1_last;
    logic [AW-1:0]    s1_addr;
    logic [ACC_W-1:0] s1_sum;

    logic             s2_vld, s2_first, s2_last, s2_fwd;
    logic [AW-1:0]    s2_addr;
    logic [ACC_W-1:0] s2_sum, s2_fwd_data;

    logic [ACC_W-1:0]        rd_data;
    logic [ACC_W-1:0]        prev;
    logic [ACC_W-1:0]        acc;
    logic signed [ACC_W-1:0] q;
    logic [7:0]              q8;
    logic                    fwd_hit;
    logic                    ram_we;
    logic                    ram_re;
    logic                    unused_addr_bits;

    assign unused_addr_bits = ^in_addr[31:AW];

    // A pending output that is not taken freezes the whole pipeline.
    assign stall   = out_vld && !out_rdy;
    assign advance = !stall;
    assign in_rdy  = (state == RUN) && !stall;
    assign accept  = in_vld && in_rdy;

    assign id_f     = in_data[ID_MSB:ID_LSB];
    assign p1_f     = in_data[P1_MSB:P1_LSB];
    assign p3_f     = in_data[P3_MSB:P3_LSB];
    assign beat_sum = ACC_W'(id_f) + ACC_W'(p1_f) + ACC_W'(p3_f);

    assign prev = s2_first ? '0 : (s2_fwd ? s2_fwd_data : rd_data);
    assign acc  = prev + s2_sum;
    assign q    = $signed(acc) >>> shift_r;

    always_comb begin
        q8 = q[7:0];
        if (q < SAT_MIN) begin
            q8 = 8'(SAT_MIN);
        end else if (q > SAT_MAX) begin
            q8 = 8'(SAT_MAX);
        end
    end

    // S2 writes and S1 reads the same entry in one cycle: RAM data would be stale.
    assign fwd_hit = s2_vld && !s2_last && s1_vld && !s1_first && (s1_addr == s2_addr);
    assign ram_we  = advance && s2_vld && !s2_last;
    assign ram_re  = advance && s1_vld && !s1_first;

    psum_acc_ram #(
        .DEPTH(PSUM_DEPTH),
        .AW   (AW),
        .DW   (ACC_W)
    ) u_ram (
        .clk  (clk),
        .we   (ram_we),
        .waddr(s2_addr),
        .wdata(acc),
        .re   (ram_re),
        .raddr(s1_addr),
        .rdata(rd_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            in_ch_r    <= 8'd1;
            map_size_r <= 16'd0;
            shift_r    <= 5'd0;
            pix_cnt    <= 16'd0;
            ch_cnt     <= 8'd0;
            acc_done   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    acc_done <= 1'b0;
                    if (acc_start) begin
                        in_ch_r    <= (in_ch == 8'd0) ? 8'd1 : in_ch;
                        map_size_r <= map_size;
                        shift_r    <= quant_shift;
                        pix_cnt    <= 16'd0;
                        ch_cnt     <= 8'd0;
                        state      <= RUN;
                    end
                end
                RUN: begin
                    if (accept) begin
                        if (pix_cnt == map_size_r - 16'd1) begin
                            pix_cnt <= 16'd0;
                            ch_cnt  <= ch_cnt + 8'd1;
                            if (ch_cnt == in_ch_r - 8'd1) begin
                                state <= DRAIN;
                            end
                        end else begin
                            pix_cnt <= pix_cnt + 16'd1;
                        end
                    end
                end
                DRAIN: begin
                    if (!s1_vld && !s2_vld && !out_vld) begin
                        state    <= DONE;
                        acc_done <= 1'b1;
                    end
                end
                DONE: begin
                    acc_done <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld      <= 1'b0;
            s1_first    <= 1'b0;
            s1_last     <= 1'b0;
            s1_addr     <= '0;
            s1_sum      <= '0;
            s2_vld      <= 1'b0;
            s2_first    <= 1'b0;
            s2_last     <= 1'b0;
            s2_addr     <= '0;
            s2_sum      <= '0;
            s2_fwd      <= 1'b0;
            s2_fwd_data <= '0;
            out_vld     <= 1'b0;
            out_data    <= 8'd0;
            out_addr    <= 32'd0;
        end else if (advance) begin
            s1_vld <= accept;
            if (accept) begin
                s1_sum   <= beat_sum;
                s1_addr  <= in_addr[AW-1:0];
                s1_first <= (ch_cnt == 8'd0);
                s1_last  <= (ch_cnt == in_ch_r - 8'd1);
            end
            s2_vld      <= s1_vld;
            s2_first    <= s1_first;
            s2_last     <= s1_last;
            s2_addr     <= s1_addr;
            s2_sum      <= s1_sum;
            s2_fwd      <= fwd_hit;
            s2_fwd_data <= acc;
            if (s2_vld && s2_last) begin
                out_vld  <= 1'b1;
                out_data <= q8;
                out_addr <= 32'(s2_addr);
            end else begin
                out_vld <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_psum_acc.sv
// Randomised self-checking bench for psum_acc against a per-pixel
// accumulation model built from the beat and requantisation rules.
module tb_psum_acc;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        acc_start = 1'b0;
    logic        acc_done;
    logic [7:0]  in_ch = 8'd1;
    logic [15:0] map_size = 16'd1;
    logic [4:0]  quant_shift = 5'd0;
    logic [31:0] in_addr = 32'd0;
    logic [63:0] in_data = 64'd0;
    logic        in_vld = 1'b0;
    logic        in_rdy;
    logic [31:0] out_addr;
    logic [7:0]  out_data;
    logic        out_vld;
    logic        out_rdy = 1'b1;

    int compared = 0;
    int mismatched = 0;
    int cyc = 0;
    bit randRdyEn = 1'b0;
    bit stallChkEn = 1'b0;

    int modelMem [1024];
    int expAddr[$], expData[$];
    int obsAddr[$], obsData[$], obsCyc[$];

    psum_acc dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .acc_start  (acc_start),
        .acc_done   (acc_done),
        .in_ch      (in_ch),
        .map_size   (map_size),
        .quant_shift(quant_shift),
        .in_addr    (in_addr),
        .in_data    (in_data),
        .in_vld     (in_vld),
        .in_rdy     (in_rdy),
        .out_addr   (out_addr),
        .out_data   (out_data),
        .out_vld    (out_vld),
        .out_rdy    (out_rdy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        forever begin
            @(posedge clk);
            #1;
            out_rdy = randRdyEn ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    always @(negedge clk) begin
        if (rst_n && out_vld && out_rdy) begin
            obsAddr.push_back(int'(out_addr));
            obsData.push_back(int'(out_data));
            obsCyc.push_back(cyc);
        end
        if (rst_n && stallChkEn && out_vld && !out_rdy) begin
            checkOutput("in_rdy_stall", 32'(in_rdy), 32'd0);
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] makeBeat(input int mode, input int pix);
        logic [63:0] b;
        case (mode)
            0: b = {8'd1, 24'd2, 32'd3};
            1: b = {8'hFF, 24'hFFFFFE, 32'd40};
            2: begin
                case (pix)
                    0:       b = {8'd0, 24'd0, 32'h7FFF_FFFF};
                    1:       b = {8'd0, 24'd0, 32'hFFFF_FFFB};
                    2:       b = {8'd0, 24'h800000, 32'd0};
                    default: b = {8'h80, 24'd0, 32'd0};
                endcase
            end
            3: b = {8'd2, 24'd3, 32'd5};
            default: b = {8'($urandom), 24'($urandom_range(0, 600)) - 24'd300,
                          32'($urandom_range(0, 4000)) - 32'd1500};
        endcase
        return b;
    endfunction

    function automatic int beatSum(input logic [63:0] b);
        logic signed [7:0]  id;
        logic signed [23:0] p1;
        logic signed [31:0] p3;
        id = b[63:56];
        p1 = b[55:32];
        p3 = b[31:0];
        return int'(id) + int'(p1) + int'(p3);
    endfunction

    function automatic int quantise(input int acc, input int sh);
        int q;
        q = acc >>> sh;
        if (q < 0) return 0;
        if (q > 127) return 127;
        return q;
    endfunction

    // Runs one output channel end to end and compares every emitted byte.
    task automatic applyStimulus(input int inCh, input int mapSize, input int shift,
                                 input int mode, input bit randAddr, input bit randRdy,
                                 input bit checkTiming);
        int effCh;
        int addrTab[$];
        logic [63:0] beats[$];
        int beatAddr[$];
        int accCyc[$];
        int acc;
        int waitCnt;
        int nOut;
        effCh = (inCh == 0) ? 1 : inCh;
        for (int p = 0; p < mapSize; p++) begin
            addrTab.push_back(randAddr ? int'($urandom_range(0, mapSize - 1)) : p);
        end
        expAddr.delete();
        expData.delete();
        for (int c = 0; c < effCh; c++) begin
            for (int p = 0; p < mapSize; p++) begin
                logic [63:0] b;
                b = makeBeat(mode, p);
                beats.push_back(b);
                beatAddr.push_back(addrTab[p]);
                acc = (c == 0) ? beatSum(b) : modelMem[addrTab[p]] + beatSum(b);
                if (c == effCh - 1) begin
                    expAddr.push_back(addrTab[p]);
                    expData.push_back(quantise(acc, shift));
                end else begin
                    modelMem[addrTab[p]] = acc;
                end
            end
        end
        obsAddr.delete();
        obsData.delete();
        obsCyc.delete();
        randRdyEn = randRdy;
        stallChkEn = randRdy;

        @(posedge clk);
        #1;
        acc_start = 1'b1;
        in_ch = 8'(inCh);
        map_size = 16'(mapSize);
        quant_shift = 5'(shift);
        @(posedge clk);
        #1;
        acc_start = 1'b0;

        for (int i = 0; i < beats.size(); i++) begin
            in_vld = 1'b1;
            in_data = beats[i];
            in_addr = 32'(beatAddr[i]);
            waitCnt = 0;
            @(negedge clk);
            while (!in_rdy && waitCnt < 1000) begin
                @(negedge clk);
                waitCnt++;
            end
            if (!in_rdy) begin
                checkOutput("in_rdy_timeout", 32'd0, 32'd1);
                break;
            end
            accCyc.push_back(cyc + 1);
            @(posedge clk);
            #1;
        end
        in_vld = 1'b0;

        waitCnt = 0;
        @(negedge clk);
        while (!acc_done && waitCnt < 2000) begin
            @(negedge clk);
            waitCnt++;
        end
        checkOutput("acc_done_seen", 32'(acc_done), 32'd1);
        @(negedge clk);
        checkOutput("acc_done_pulse", 32'(acc_done), 32'd0);

        checkOutput("out_count", 32'(obsData.size()), 32'(expData.size()));
        nOut = (obsData.size() < expData.size()) ? obsData.size() : expData.size();
        for (int i = 0; i < nOut; i++) begin
            checkOutput("out_data", 32'(obsData[i]), 32'(expData[i]));
            checkOutput("out_addr", 32'(obsAddr[i]), 32'(expAddr[i]));
        end
        if (checkTiming && accCyc.size() == beats.size() && obsCyc.size() > 0) begin
            checkOutput("no_bubble", 32'(accCyc[accCyc.size() - 1] - accCyc[0]),
                        32'(beats.size() - 1));
            checkOutput("latency", 32'(obsCyc[0] - accCyc[(effCh - 1) * mapSize]), 32'd2);
        end
        randRdyEn = 1'b0;
        stallChkEn = 1'b0;
    endtask

    initial begin
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("rst_in_rdy", 32'(in_rdy), 32'd0);
        checkOutput("rst_out_vld", 32'(out_vld), 32'd0);
        checkOutput("rst_out_data", 32'(out_data), 32'd0);
        checkOutput("rst_out_addr", out_addr, 32'd0);
        checkOutput("rst_acc_done", 32'(acc_done), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        applyStimulus(1, 4, 0, 0, 1'b0, 1'b0, 1'b1);
        applyStimulus(3, 2, 2, 1, 1'b0, 1'b0, 1'b1);
        applyStimulus(1, 4, 0, 2, 1'b0, 1'b0, 1'b1);
        applyStimulus(4, 1, 0, 3, 1'b0, 1'b0, 1'b1);
        applyStimulus(2, 8, 1, 4, 1'b0, 1'b1, 1'b0);
        applyStimulus(3, 16, 3, 4, 1'b1, 1'b1, 1'b0);
        applyStimulus(0, 5, 0, 4, 1'b0, 1'b0, 1'b1);

        // Abandon a multi-pass channel halfway through with an async reset.
        @(posedge clk);
        #1;
        acc_start = 1'b1;
        in_ch = 8'd3;
        map_size = 16'd4;
        @(posedge clk);
        #1;
        acc_start = 1'b0;
        in_vld = 1'b1;
        in_data = {8'd50, 24'd60, 32'd70};
        in_addr = 32'd0;
        repeat (6) @(posedge clk);
        #2;
        in_vld = 1'b0;
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_out_vld", 32'(out_vld), 32'd0);
        checkOutput("midrst_out_data", 32'(out_data), 32'd0);
        checkOutput("midrst_in_rdy", 32'(in_rdy), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        applyStimulus(1, 4, 0, 0, 1'b0, 1'b0, 1'b1);
        applyStimulus(2, 6, 2, 4, 1'b1, 1'b0, 1'b1);
        for (int k = 0; k < 4; k++) begin
            applyStimulus($urandom_range(1, 5), $urandom_range(1, 20), $urandom_range(0, 6),
                          4, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/psum_acc.md
Name: psum_acc

Overview:
- Downstream stage of the MAC array. Consumes its 64-bit packed beats: [63:56] identity int8, [55:32] 1x1 psum int24, [31:0] 3x3 psum int32.
- Sums the three RepVGG branches per pixel and accumulates across input-channel passes in a local psum RAM.
- On the last pass, applies requantise shift, ReLU and int8 saturation, then streams one byte per pixel to the omap writer.
- One instance handles one output channel.

Parameters:
- PSUM_DEPTH, 1024, psum RAM entries (pixels per map, max).
- AW, 10, psum RAM address width, equal to log2(PSUM_DEPTH).
- ACC_W, 32, accumulator width (two's complement, wraps).

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset. Asynchronous assert, active-low.
- acc_start  in  1  one-cycle pulse. Latches cfg and starts an output channel.
- acc_done  out  1  one-cycle pulse after the last output beat is accepted.
- in_ch  in  8  input-channel passes per output channel. 0 is treated as 1.
- map_size  in  16  pixels per pass. Range 1..PSUM_DEPTH.
- quant_shift  in  5  arithmetic right shift applied before saturation.
- in_addr  in  32  pixel address. Bits [AW-1:0] index the RAM.
- in_data  in  64  packed psum beat.
- in_vld  in  1  beat valid.
- in_rdy  out  1  beat accepted when in_vld && in_rdy.
- out_addr  out  32  pixel address of output byte, zero-extended.
- out_data  out  8  int8 result.
- out_vld  out  1  output valid.
- out_rdy  in  1  output accepted when out_vld && out_rdy.

Behaviour:
- Reset values: in_rdy=0, out_vld=0, out_data=0, out_addr=0, acc_done=0; FSM=IDLE; counters=0; pipeline valids=0.
- FSM IDLE: in_rdy=0. On acc_start, latch in_ch (min 1), map_size, quant_shift; clear pix_cnt and ch_cnt; go to RUN.
- FSM RUN: in_rdy = !stall.
  - Each accepted beat increments pix_cnt. At map_size-1, pix_cnt wraps to 0 and ch_cnt increments.
  - The beat with ch_cnt==in_ch-1 and pix_cnt==map_size-1 moves the FSM to DRAIN.
- FSM DRAIN: in_rdy=0. When both pipeline stages are empty and no out_vld is pending, go to DONE.
- FSM DONE: acc_done=1 for one cycle, then IDLE.
- acc_start outside IDLE is ignored.
- Beat sum: sext(id8) + sext(p1x1_24) + p3x3_32, computed in ACC_W and wrapping.
- Pipeline stage S1 (accept): register the beat and its flags first=(ch_cnt==0) and last=(ch_cnt==in_ch-1). Issue the RAM read at addr, except on a first pass.
- Pipeline stage S2 (one cycle later, RAM read latency 1):
  - acc = (first ? 0 : rd_data) + sum.
  - If !last, write acc back to the RAM.
  - If last, do not write. Instead load the output register:
    - q = acc >>> quant_shift (arithmetic).
    - ReLU: q<0 gives 0.
    - Saturate: q>127 gives 127.
    - out_data = q[7:0], out_addr = addr, out_vld = 1.
- Stall: stall = out_vld && !out_rdy. Stall freezes S1, S2 and the RAM read-data hold, and forces in_rdy=0. No beat is ever dropped.
- Hazard: if S2 writes the same address that S1 reads in the same cycle (map_size==1 or repeated addr), S1 takes the S2 write data via a forwarding mux, not RAM data.
- Throughput: 1 beat/cycle with no stall. Latency is 2 cycles from input accept to out_vld on the last pass.
- in_ch==1: every beat is both first and last. The RAM is never read or written.
- Reset mid-operation: all state is lost, FSM returns to IDLE, and RAM contents become don't-care (the next first pass overwrites them).

Decomposition:
- Package psum_acc_pkg:
  - Field positions ID_MSB/LSB, P1_MSB/LSB, P3_MSB/LSB.
  - Widths ID_W=8, P1_W=24, P3_W=32.
  - State encoding IDLE/RUN/DRAIN/DONE.
  - Saturation constants 127/0.
- Sub-module psum_ram:
  - Simple dual-port RAM, PSUM_DEPTH x ACC_W, one write port and one registered read port.
  - Read has no read-during-write guarantee; psum_acc's own forwarding mux covers that case.

Test Plan:
- in_ch=1, map_size=4, shift=0, beats (id=1, 1x1=2, 3x3=3) -> four out beats of 6 at addrs 0..3, then acc_done pulse.
- in_ch=3, map_size=2, shift=2, every beat (id=-1, 1x1=-2, 3x3=40) sum 37 -> 111>>>2 = 27 at addrs 0 and 1.
- Saturation/ReLU, in_ch=1, shift=0: 3x3 = 0x7FFF_FFFF -> 127; 3x3=-5, others 0 -> 0; 1x1 = 0x800000 (-8388608) sign-extended -> 0.
- Forwarding: in_ch=4, map_size=1, back-to-back beats each sum 10 -> single out 40 with no bubble inserted.
- Backpressure: in_ch=2, map_size=8, out_rdy toggled randomly -> in_rdy deasserts while stalled and all 8 outputs arrive in order with correct values.
- rst_n pulled low during RUN, then a new acc_start with in_ch=1 -> outputs 0 during reset and correct results after, with no stale psum contribution.
